// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF fetch sequencer (fetch_ctrl).
package fetch_ctrl_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned DEF_FIFO_WIDTH = 131;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_7C00;

    // Field offsets inside an instbuffer entry
    localparam int unsigned INST_LSB = 0;
    localparam int unsigned PC_LSB   = 32;
    localparam int unsigned ADEF_BIT = 64;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DISCARD,
        FETCH_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_FIFO_WIDTH-ADEF_BIT-2:0] rsvd;
        logic                               adef;
        logic [XLEN-1:0]                    pc;
        logic [XLEN-1:0]                    inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Cache read handshake plus instbuffer two-slot write port, seen from fetch_ctrl.
interface fetch_ctrl_if #(
    parameter int unsigned FIFO_WIDTH = 131
) ();

    logic                  inst_req_o;
    logic [31:0]           inst_addr_o;
    logic                  inst_addr_ok_i;
    logic                  inst_data_ok_i;
    logic [63:0]           inst_rdata_i;
    logic                  instbuffer_allowin_i;
    logic                  bus1_valid_o;
    logic                  bus2_valid_o;
    logic [FIFO_WIDTH-1:0] bus1_o;
    logic [FIFO_WIDTH-1:0] bus2_o;

    modport master (
        output inst_req_o, inst_addr_o,
        output bus1_valid_o, bus2_valid_o, bus1_o, bus2_o,
        input  inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
        input  instbuffer_allowin_i
    );

    modport slave (
        input  inst_req_o, inst_addr_o,
        input  bus1_valid_o, bus2_valid_o, bus1_o, bus2_o,
        output inst_addr_ok_i, inst_data_ok_i, inst_rdata_i,
        output instbuffer_allowin_i
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding I-cache read, pushes instruction pairs into instbuffer.
// Optional FETCH_PERF_CNT_EN adds discard/stall counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        exception_flag_i,
    input  logic [31:0] exception_entry_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] discard_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    fetch_ctrl_if.master fif
);

    fetch_state_e          state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           req_pc_q, req_pc_d;
    logic                  stale_q, stale_d;
    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  push1, push2;
    logic [FIFO_WIDTH-1:0] entry1, entry2;

    function automatic logic [FIFO_WIDTH-1:0] pack_entry(input logic [31:0] inst,
                                                         input logic [31:0] pc,
                                                         input logic        adef);
        logic [FIFO_WIDTH-1:0] e;
        e                    = '0;
        e[INST_LSB +: XLEN]  = inst;
        e[PC_LSB +: XLEN]    = pc;
        e[ADEF_BIT]          = adef;
        return e;
    endfunction

    // Exception has priority over branch
    assign redirect    = branch_flag_i | exception_flag_i;
    assign redirect_pc = exception_flag_i ? exception_entry_i : branch_target_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            stale_q  <= stale_d;
        end
    end

    // Next state, PC update and same-cycle push of a returning response
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        stale_d  = stale_q;
        push1    = 1'b0;
        push2    = 1'b0;
        entry1   = '0;
        entry2   = '0;

        unique case (state_q)
            FETCH_IDLE: begin
                if (pc_q[1:0] != 2'b00) begin
                    if (!redirect) begin
                        push1   = 1'b1;
                        entry1  = pack_entry(32'h0, pc_q, 1'b1);
                        state_d = FETCH_HALT;
                    end
                end else if (!redirect && fif.instbuffer_allowin_i) begin
                    req_pc_d = pc_q;
                    state_d  = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                // A redirect cannot retract an issued request; remember it must be discarded
                if (fif.inst_addr_ok_i) begin
                    state_d = (stale_q || redirect) ? FETCH_DISCARD : FETCH_WAIT;
                    stale_d = 1'b0;
                end else if (redirect) begin
                    stale_d = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (fif.inst_data_ok_i) begin
                    state_d = FETCH_IDLE;
                    if (!redirect) begin
                        push1  = 1'b1;
                        entry1 = pack_entry(fif.inst_rdata_i[31:0], req_pc_q, 1'b0);
                        push2  = ~req_pc_q[2];
                        if (!req_pc_q[2]) begin
                            entry2 = pack_entry(fif.inst_rdata_i[63:32], req_pc_q + 32'd4, 1'b0);
                        end
                        pc_d = req_pc_q + (req_pc_q[2] ? 32'd4 : 32'd8);
                    end
                end else if (redirect) begin
                    state_d = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (fif.inst_data_ok_i) begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_HALT: begin
                if (redirect) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_pc;
        end
    end

    assign fif.inst_req_o   = (state_q == FETCH_REQ);
    assign fif.inst_addr_o  = req_pc_q;
    assign fif.bus1_valid_o = push1;
    assign fif.bus2_valid_o = push2;
    assign fif.bus1_o       = entry1;
    assign fif.bus2_o       = entry2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] discard_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        drop_c;
    logic        stall_c;

    assign drop_c  = fif.inst_data_ok_i &&
                     ((state_q == FETCH_DISCARD) || ((state_q == FETCH_WAIT) && redirect));
    assign stall_c = (state_q == FETCH_IDLE) && !fif.instbuffer_allowin_i;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (drop_c && (discard_cnt_q != '1)) begin
                discard_cnt_q <= discard_cnt_q + 32'd1;
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign discard_cnt_o = discard_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table plus redirect/stall/misalign sequences.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int unsigned FW = DEF_FIFO_WIDTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        exception_flag;
    logic [31:0] exception_entry;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] discard_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_ctrl_if #(.FIFO_WIDTH(FW)) fif ();

    fetch_ctrl #(.FIFO_WIDTH(FW), .RESET_PC(DEF_RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .branch_flag_i     (branch_flag),
        .branch_target_i   (branch_target),
        .exception_flag_i  (exception_flag),
        .exception_entry_i (exception_entry),
`ifdef FETCH_PERF_CNT_EN
        .discard_cnt_o     (discard_cnt),
        .stall_cnt_o       (stall_cnt),
`endif
        .fif               (fif)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic          slot2;
        logic [FW-1:0] entry;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic        br;
        logic        exc;
        logic [31:0] tgt;
        logic [31:0] ent;
        logic [31:0] addr;
        logic [63:0] rdata;
        int          aok;
        int          dok;
    } vec_t;
    vec_t vt[7];

    function automatic logic [FW-1:0] mk(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic adef);
        fetch_entry_t e;
        e      = '0;
        e.inst = inst;
        e.pc   = pc;
        e.adef = adef;
        return e;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every push must match the head of the queue, nothing may be left over
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (fif.bus1_valid_o) begin
                if (exp_q.size() == 0 || exp_q[0].slot2) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_bus1: got %h expected no push", fif.bus1_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_bus("bus1", fif.bus1_o, mon_e.entry);
                end
            end
            if (fif.bus2_valid_o) begin
                if (exp_q.size() == 0 || !exp_q[0].slot2) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_bus2: got %h expected no push", fif.bus2_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_bus("bus2", fif.bus2_o, mon_e.entry);
                end
            end
            if (exp_q.size() != 0) begin
                n_vec++; n_bad++;
                $display("FAIL missing_push: got no push expected %0d entries", exp_q.size());
                exp_q.delete();
            end
        end
    end

    task automatic expect_resp(input logic [31:0] addr, input logic [63:0] rdata);
        exp_q.push_back('{1'b0, mk(rdata[31:0], addr, 1'b0)});
        if (!addr[2]) begin
            exp_q.push_back('{1'b1, mk(rdata[63:32], addr + 32'd4, 1'b0)});
        end
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n;
        n = 0;
        while (!fif.inst_req_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (!fif.inst_req_o) begin
            n_bad++;
            $display("FAIL req_timeout: got no request expected addr %h", addr);
        end else begin
            n_vec--;
            chk32("req_addr", fif.inst_addr_o, addr);
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [63:0] rdata,
                            input int aok_dly, input int dok_dly);
        wait_req(addr);
        for (int i = 0; i < aok_dly; i++) begin
            @(negedge clk);
            chk32("req_hold", 32'(fif.inst_req_o), 32'd1);
            chk32("addr_hold", fif.inst_addr_o, addr);
        end
        fif.inst_addr_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_addr_ok_i = 1'b0;
        chk32("req_low_in_wait", 32'(fif.inst_req_o), 32'd0);
        for (int i = 0; i < dok_dly; i++) @(negedge clk);
        expect_resp(addr, rdata);
        fif.inst_rdata_i   = rdata;
        fif.inst_data_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_data_ok_i = 1'b0;
    endtask

    task automatic redirect(input logic br, input logic exc, input logic [31:0] tgt,
                            input logic [31:0] ent);
        branch_flag     = br;
        exception_flag  = exc;
        branch_target   = tgt;
        exception_entry = ent;
        @(negedge clk);
        branch_flag    = 1'b0;
        exception_flag = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                      = 1'b1;
        branch_flag              = 1'b0;
        exception_flag           = 1'b0;
        branch_target            = '0;
        exception_entry          = '0;
        fif.inst_addr_ok_i       = 1'b0;
        fif.inst_data_ok_i       = 1'b0;
        fif.inst_rdata_i         = '0;
        fif.instbuffer_allowin_i = 1'b1;

        vt[0] = '{1'b0, 1'b0, 32'h0,         32'h0,    32'h0000_7C00, 64'h22222222_11111111, 0, 1};
        vt[1] = '{1'b0, 1'b0, 32'h0,         32'h0,    32'h0000_7C08, 64'hAAAA5555_12345678, 2, 0};
        vt[2] = '{1'b1, 1'b0, 32'h1004,      32'h0,    32'h0000_1004, 64'hDEADBEEF_CAFEF00D, 0, 1};
        vt[3] = '{1'b0, 1'b0, 32'h0,         32'h0,    32'h0000_1008, 64'h0BADC0DE_01234567, 1, 2};
        vt[4] = '{1'b1, 1'b1, 32'h4000,      32'h8000, 32'h0000_8000, 64'h89ABCDEF_76543210, 0, 0};
        vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,    32'hFFFF_FFF8, 64'h55555555_AAAAAAAA, 0, 1};
        vt[6] = '{1'b0, 1'b0, 32'h0,         32'h0,    32'h0000_0000, 64'h13579BDF_2468ACE0, 1, 1};

        repeat (2) @(negedge clk);
        chk32("rst_req", 32'(fif.inst_req_o), 32'd0);
        chk32("rst_addr", fif.inst_addr_o, 32'h0000_7C00);
        chk32("rst_v1", 32'(fif.bus1_valid_o), 32'd0);
        chk32("rst_v2", 32'(fif.bus2_valid_o), 32'd0);
        chk_bus("rst_bus1", fif.bus1_o, '0);
        chk_bus("rst_bus2", fif.bus2_o, '0);
`ifdef FETCH_PERF_CNT_EN
        chk32("rst_discard_cnt", discard_cnt, 32'd0);
        chk32("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0;

        // Table: optional redirect while IDLE, then one full fetch
        for (int i = 0; i < 7; i++) begin
            if (vt[i].br || vt[i].exc) redirect(vt[i].br, vt[i].exc, vt[i].tgt, vt[i].ent);
            do_fetch(vt[i].addr, vt[i].rdata, vt[i].aok, vt[i].dok);
        end

        // Branch in WAIT, response two cycles later is dropped
        wait_req(32'h0000_0008);
        fif.inst_addr_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_addr_ok_i = 1'b0;
        redirect(1'b1, 1'b0, 32'h3000, 32'h0);
        @(negedge clk);
        fif.inst_rdata_i   = 64'hFFFFFFFF_EEEEEEEE;
        fif.inst_data_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_data_ok_i = 1'b0;
        do_fetch(32'h3000, 64'h31313131_30303030, 0, 0);

        // Branch in the same cycle as data_ok: flush wins, no push
        wait_req(32'h3008);
        fif.inst_addr_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_addr_ok_i = 1'b0;
        fif.inst_rdata_i   = 64'h77777777_66666666;
        fif.inst_data_ok_i = 1'b1;
        redirect(1'b1, 1'b0, 32'h5000, 32'h0);
        fif.inst_data_ok_i = 1'b0;
        do_fetch(32'h5000, 64'h51515151_50505050, 0, 1);

        // Branch while the request is still pending: request held, later discarded
        wait_req(32'h5008);
        redirect(1'b1, 1'b0, 32'h6000, 32'h0);
        chk32("stale_req_held", 32'(fif.inst_req_o), 32'd1);
        chk32("stale_addr_held", fif.inst_addr_o, 32'h5008);
        fif.inst_addr_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_addr_ok_i = 1'b0;
        fif.inst_rdata_i   = 64'h99999999_88888888;
        fif.inst_data_ok_i = 1'b1;
        @(negedge clk);
        fif.inst_data_ok_i = 1'b0;
        do_fetch(32'h6000, 64'h61616161_60606060, 0, 0);

        // allowin low for five IDLE cycles
        fif.instbuffer_allowin_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk32("stall_no_req", 32'(fif.inst_req_o), 32'd0);
            @(negedge clk);
        end
        fif.instbuffer_allowin_i = 1'b1;
        chk32("stall_no_req_rise", 32'(fif.inst_req_o), 32'd0);
        @(negedge clk);
        chk32("req_after_allowin", 32'(fif.inst_req_o), 32'd1);
        do_fetch(32'h6008, 64'h71717171_70707070, 0, 1);
`ifdef FETCH_PERF_CNT_EN
        chk32("stall_cnt", stall_cnt, 32'd5);
`endif

        // Misaligned target: one adef push, no request, halt until redirect
        redirect(1'b1, 1'b0, 32'h1002, 32'h0);
        exp_q.push_back('{1'b0, mk(32'h0, 32'h1002, 1'b1)});
        chk32("adef_no_req", 32'(fif.inst_req_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk32("halt_no_req", 32'(fif.inst_req_o), 32'd0);
        end
        redirect(1'b1, 1'b0, 32'h2000, 32'h0);
        do_fetch(32'h2000, 64'h21212121_20202020, 0, 1);

        repeat (2) @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        chk32("discard_cnt", discard_cnt, 32'd3);
`endif
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
